rename_register_file: RTL and testbench
=======================================

Name: rename_register_file

Overview:
- Architectural register file plus per-register rename-label table.
- Sits between the decoder and the reorder buffer.
  - Decoder side: the decoder renames a destination register to a ROB tag at issue.
  - Lookup side: the ROB reads source labels and values to build RS operands.
  - Commit side: the ROB's commit port writes back values and clears labels.
- Flush drops all pending renames and keeps committed architectural state.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
REG_WIDTH, 5, register index width
VAL_WIDTH, 32, register value width
ROB_ID_WIDTH, 5, rename label width; label 0 means "no pending producer"

Ports:
clk  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous reset, active-low
rdy_in  input  1  global ready; when 0 all state holds
flush_in  input  1  misprediction flush
dec_en  input  1  rename request this cycle
dec_rd  input  REG_WIDTH  destination register being renamed
dec_tag  input  ROB_ID_WIDTH  ROB label assigned to dec_rd (nonzero)
rs1  input  REG_WIDTH  source register 1 index
rs2  input  REG_WIDTH  source register 2 index
commit_en  input  1  commit write valid this cycle
commit_rd  input  REG_WIDTH  committed destination register
commit_res  input  VAL_WIDTH  committed value
commit_lab  input  ROB_ID_WIDTH  ROB label of committing entry
rf_label1  output  ROB_ID_WIDTH  pending label of rs1 (0 = value valid)
rf_val1  output  VAL_WIDTH  value of rs1
rf_label2  output  ROB_ID_WIDTH  pending label of rs2
rf_val2  output  VAL_WIDTH  value of rs2

Behaviour:
- State: regs[0..REG_NUM-1] (VAL_WIDTH) and label[0..REG_NUM-1] (ROB_ID_WIDTH).
- Reset (rst_in==0 at a posedge; overrides rdy_in and flush_in):
  - All regs and all labels go to 0.
  - Outputs combinationally follow this state, so they read 0 the cycle after reset.
  - Reset mid-operation discards any same-cycle rename or commit.
- rdy_in==0: no state change; outputs remain combinational on the held state.
- Commit (commit_en && rdy_in, commit_rd!=0):
  - regs[commit_rd] <= commit_res.
  - If label[commit_rd]==commit_lab, label[commit_rd] <= 0; otherwise the label is untouched, because a younger rename is still pending.
  - commit_rd==0 is ignored entirely.
- Rename (dec_en && rdy_in && !flush_in, dec_rd!=0):
  - label[dec_rd] <= dec_tag; regs unchanged.
  - dec_rd==0 is ignored.
- Rename and commit to the same register in the same cycle: the value is written and the label becomes dec_tag (rename wins).
- Flush (flush_in && rdy_in):
  - Every label <= 0.
  - A same-cycle commit value write still happens.
  - A same-cycle rename is dropped.
  - Flush is single-cycle; the next cycle behaves normally.
- Read ports are combinational, identical for port 1/rs1 and port 2/rs2:
  - rsX==0: label 0, value 0.
  - Commit bypass: if commit_en && rdy_in && commit_rd==rsX && commit_rd!=0 && label[rsX]==commit_lab, output label 0 and value commit_res.
  - Otherwise output label[rsX] and regs[rsX].
  - The read does not see a same-cycle rename. An instruction renaming its own source reads the old mapping; the new label is visible from the next cycle.
- Latency: write-to-read is 0 cycles through the bypass, 1 cycle through the array. Rename becomes visible after 1 cycle.
- Label value 0 is never a valid ROB tag; dec_tag==0 is illegal input, and the design does not check it.

Optional Feature:
- Macro: RF_PERF_CNT_EN.
- Defined:
  - Adds output perf_commit_cnt (32) and output perf_rename_cnt (32).
  - perf_commit_cnt increments once per accepted commit with commit_rd!=0.
  - perf_rename_cnt increments once per accepted rename, excluding renames dropped by flush or rd==0.
  - Both cleared by reset, hold when rdy_in==0, wrap modulo 2^32.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_in=0 two cycles, release -> rf_label1/2=0, rf_val1/2=0 for rs1=5, rs2=31.
- Rename then commit, label matches: dec_en, rd=3, tag=7 -> next cycle rs1=3 gives label 7. Then commit_en, rd=3, res=0x1234, lab=7 -> same cycle bypass rf_label1=0, rf_val1=0x1234; next cycle array holds the same.
- Stale commit: rename x4->tag 2, then rename x4->tag 9, then commit rd=4, lab=2, res=0xAA -> regs[4]=0xAA, rf_label for x4 stays 9, no bypass.
- Same-cycle rename and commit to x6, tag 5, old label 5 -> next cycle label 5, regs[6]=commit_res.
- Flush: labels x1=3, x2=4; assert flush_in with dec_en rd=8, tag=6 and commit rd=1, lab=3, res=0x55 -> next cycle all labels 0, regs[1]=0x55, x8 not renamed.
- x0 and rdy_in: rename x0 and commit x0 res=0xFF -> rs1=0 reads label 0, value 0. With rdy_in=0, rename x10 -> label of x10 unchanged.

Source files
------------

// File: rtl/rename_register_file_if.sv
// Decoder/ROB-facing bundle of the rename register file: rename, commit and two source-read ports.
// Optional perf counter outputs exist only when RF_PERF_CNT_EN is defined.
interface rename_register_file_if #(
  parameter int REG_WIDTH    = 5,
  parameter int VAL_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 5
);
  logic                    rdy_in;
  logic                    flush_in;
  logic                    dec_en;
  logic [REG_WIDTH-1:0]    dec_rd;
  logic [ROB_ID_WIDTH-1:0] dec_tag;
  logic [REG_WIDTH-1:0]    rs1;
  logic [REG_WIDTH-1:0]    rs2;
  logic                    commit_en;
  logic [REG_WIDTH-1:0]    commit_rd;
  logic [VAL_WIDTH-1:0]    commit_res;
  logic [ROB_ID_WIDTH-1:0] commit_lab;
  logic [ROB_ID_WIDTH-1:0] rf_label1;
  logic [VAL_WIDTH-1:0]    rf_val1;
  logic [ROB_ID_WIDTH-1:0] rf_label2;
  logic [VAL_WIDTH-1:0]    rf_val2;
`ifdef RF_PERF_CNT_EN
  logic [31:0]             perf_commit_cnt;
  logic [31:0]             perf_rename_cnt;
`endif

  modport master (
    output rdy_in, flush_in, dec_en, dec_rd, dec_tag, rs1, rs2,
           commit_en, commit_rd, commit_res, commit_lab,
`ifdef RF_PERF_CNT_EN
    input  perf_commit_cnt, perf_rename_cnt,
`endif
    input  rf_label1, rf_val1, rf_label2, rf_val2
  );

  modport slave (
    input  rdy_in, flush_in, dec_en, dec_rd, dec_tag, rs1, rs2,
           commit_en, commit_rd, commit_res, commit_lab,
`ifdef RF_PERF_CNT_EN
    output perf_commit_cnt, perf_rename_cnt,
`endif
    output rf_label1, rf_val1, rf_label2, rf_val2
  );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename labels; reads are combinational with a 0-cycle
// commit bypass, renames visible after 1 cycle; rdy_in=0 freezes all state. Option: RF_PERF_CNT_EN.
module rename_register_file #(
  parameter int REG_NUM      = 32,
  parameter int REG_WIDTH    = 5,
  parameter int VAL_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 5
) (
  input logic                 clk,
  input logic                 rst_in,
  rename_register_file_if.slave rf
);

  logic [VAL_WIDTH-1:0]    regs_q  [REG_NUM];
  logic [VAL_WIDTH-1:0]    regs_d  [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] label_q [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] label_d [REG_NUM];

  logic commit_fire;
  logic rename_fire;
  logic flush_fire;

  assign commit_fire = rf.commit_en && rf.rdy_in && (rf.commit_rd != '0);
  assign flush_fire  = rf.flush_in && rf.rdy_in;
  assign rename_fire = rf.dec_en && rf.rdy_in && !rf.flush_in && (rf.dec_rd != '0);

  // Commit is applied first so a same-cycle rename of the same register overwrites the label.
  always_comb begin
    regs_d  = regs_q;
    label_d = label_q;
    if (commit_fire) begin
      regs_d[rf.commit_rd] = rf.commit_res;
      if (label_q[rf.commit_rd] == rf.commit_lab) begin
        label_d[rf.commit_rd] = '0;
      end
    end
    if (flush_fire) begin
      for (int i = 0; i < REG_NUM; i++) begin
        label_d[i] = '0;
      end
    end else if (rename_fire) begin
      label_d[rf.dec_rd] = rf.dec_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i]  <= '0;
        label_q[i] <= '0;
      end
    end else begin
      regs_q  <= regs_d;
      label_q <= label_d;
    end
  end

  // A matching commit forwards its result; a stale commit (label mismatch) is not forwarded.
  always_comb begin
    rf.rf_label1 = label_q[rf.rs1];
    rf.rf_val1   = regs_q[rf.rs1];
    if (rf.rs1 == '0) begin
      rf.rf_label1 = '0;
      rf.rf_val1   = '0;
    end else if (commit_fire && (rf.commit_rd == rf.rs1) &&
                 (label_q[rf.rs1] == rf.commit_lab)) begin
      rf.rf_label1 = '0;
      rf.rf_val1   = rf.commit_res;
    end
  end

  always_comb begin
    rf.rf_label2 = label_q[rf.rs2];
    rf.rf_val2   = regs_q[rf.rs2];
    if (rf.rs2 == '0) begin
      rf.rf_label2 = '0;
      rf.rf_val2   = '0;
    end else if (commit_fire && (rf.commit_rd == rf.rs2) &&
                 (label_q[rf.rs2] == rf.commit_lab)) begin
      rf.rf_label2 = '0;
      rf.rf_val2   = rf.commit_res;
    end
  end

`ifdef RF_PERF_CNT_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] rename_cnt_q, rename_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    rename_cnt_d = rename_cnt_q;
    if (commit_fire) commit_cnt_d = commit_cnt_q + 32'd1;
    if (rename_fire) rename_cnt_d = rename_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      commit_cnt_q <= '0;
      rename_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      rename_cnt_q <= rename_cnt_d;
    end
  end

  assign rf.perf_commit_cnt = commit_cnt_q;
  assign rf.perf_rename_cnt = rename_cnt_q;
`endif

endmodule

// File: tb/tb_rename_register_file.sv
// Directed vector table for the rename/commit/flush corner cases, then random traffic against an array model.
module tb_rename_register_file;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rename_register_file_if #(.REG_WIDTH(5), .VAL_WIDTH(32), .ROB_ID_WIDTH(5)) rf_if ();

  rename_register_file #(.REG_NUM(32), .REG_WIDTH(5), .VAL_WIDTH(32), .ROB_ID_WIDTH(5)) dut (
    .clk    (clk),
    .rst_in (rst_n),
    .rf     (rf_if)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        den;
    logic [4:0]  drd;
    logic [4:0]  dtag;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        cen;
    logic [4:0]  crd;
    logic [31:0] cres;
    logic [4:0]  clab;
    logic        chk;
    logic [4:0]  l1;
    logic [31:0] v1;
    logic [4:0]  l2;
    logic [31:0] v2;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // Reference state: committed values and pending labels per architectural register.
  logic [31:0] mreg [32];
  logic [4:0]  mlab [32];
  int unsigned mcommits;
  int unsigned mrenames;

  task automatic add(input logic rst, rdy, flush, den, input logic [4:0] drd, dtag, rs1, rs2,
                     input logic cen, input logic [4:0] crd, input logic [31:0] cres,
                     input logic [4:0] clab, input logic chk, input logic [4:0] l1,
                     input logic [31:0] v1, input logic [4:0] l2, input logic [31:0] v2);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.flush = flush; v.den = den; v.drd = drd; v.dtag = dtag;
    v.rs1 = rs1; v.rs2 = rs2; v.cen = cen; v.crd = crd; v.cres = cres; v.clab = clab;
    v.chk = chk; v.l1 = l1; v.v1 = v1; v.l2 = l2; v.v2 = v2;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n              = v.rst;
    rf_if.rdy_in       = v.rdy;
    rf_if.flush_in     = v.flush;
    rf_if.dec_en       = v.den;
    rf_if.dec_rd       = v.drd;
    rf_if.dec_tag      = v.dtag;
    rf_if.rs1          = v.rs1;
    rf_if.rs2          = v.rs2;
    rf_if.commit_en    = v.cen;
    rf_if.commit_rd    = v.crd;
    rf_if.commit_res   = v.cres;
    rf_if.commit_lab   = v.clab;
  endtask

  // Expected read of one source from the model, including the forward of a matching commit.
  task automatic model_read(input vec_t v, input logic [4:0] rs,
                            output logic [4:0] lab, output logic [31:0] val);
    if (rs == 5'd0) begin
      lab = 5'd0; val = 32'd0;
    end else if (v.cen && v.rdy && v.crd == rs && mlab[rs] == v.clab) begin
      lab = 5'd0; val = v.cres;
    end else begin
      lab = mlab[rs]; val = mreg[rs];
    end
  endtask

  task automatic model_step(input vec_t v);
    if (!v.rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = 32'd0;
        mlab[i] = 5'd0;
      end
      mcommits = 0;
      mrenames = 0;
    end else if (v.rdy) begin
      if (v.cen && v.crd != 5'd0) begin
        mreg[v.crd] = v.cres;
        if (mlab[v.crd] == v.clab) mlab[v.crd] = 5'd0;
        mcommits++;
      end
      if (v.flush) begin
        for (int i = 0; i < 32; i++) mlab[i] = 5'd0;
      end else if (v.den && v.drd != 5'd0) begin
        mlab[v.drd] = v.dtag;
        mrenames++;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [4:0]  el1, el2;
    logic [31:0] ev1, ev2;

    v = '{default: '0};
    v.rdy = 1'b1;
    drive(v);

    //   rst rdy fl den drd dtag rs1 rs2 cen crd cres       clab chk l1 v1          l2 v2
    add(0, 1, 0, 0, 0,  0,  5,  31, 0, 0, 32'h0,     0,  0,  0, 32'h0,     0, 32'h0);
    add(0, 1, 0, 0, 0,  0,  5,  31, 0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  5,  31, 0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 1, 3,  7,  3,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  3,  3,  0, 0, 32'h0,     0,  1,  7, 32'h0,     7, 32'h0);
    add(1, 1, 0, 0, 0,  0,  3,  3,  1, 3, 32'h1234,  7,  1,  0, 32'h1234,  0, 32'h1234);
    add(1, 1, 0, 0, 0,  0,  3,  0,  0, 0, 32'h0,     0,  1,  0, 32'h1234,  0, 32'h0);
    add(1, 1, 0, 1, 4,  2,  4,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 1, 4,  9,  4,  0,  0, 0, 32'h0,     0,  1,  2, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  4,  0,  1, 4, 32'hAA,    2,  1,  9, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  4,  4,  0, 0, 32'h0,     0,  1,  9, 32'hAA,    9, 32'hAA);
    add(1, 1, 0, 1, 6,  5,  6,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 1, 6,  5,  6,  6,  1, 6, 32'h66,    5,  1,  0, 32'h66,    0, 32'h66);
    add(1, 1, 0, 0, 0,  0,  6,  0,  0, 0, 32'h0,     0,  1,  5, 32'h66,    0, 32'h0);
    add(1, 1, 0, 1, 1,  3,  1,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 1, 2,  4,  1,  2,  0, 0, 32'h0,     0,  1,  3, 32'h0,     0, 32'h0);
    add(1, 1, 1, 1, 8,  6,  1,  2,  1, 1, 32'h55,    3,  1,  0, 32'h55,    4, 32'h0);
    add(1, 1, 0, 0, 0,  0,  8,  2,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  1,  6,  0, 0, 32'h0,     0,  1,  0, 32'h55,    0, 32'h66);
    add(1, 1, 0, 1, 0,  3,  0,  0,  1, 0, 32'hFF,    0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  0,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 0, 0, 1, 10, 12, 10, 0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  10, 4,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'hAA);
    add(1, 0, 0, 0, 0,  0,  5,  0,  1, 5, 32'h77,    0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 0, 0,  0,  5,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(1, 1, 0, 1, 9,  3,  9,  0,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);
    add(0, 1, 0, 0, 0,  0,  9,  1,  1, 1, 32'h99,    5,  1,  3, 32'h0,     0, 32'h55);
    add(1, 1, 0, 0, 0,  0,  9,  1,  0, 0, 32'h0,     0,  1,  0, 32'h0,     0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_label1", i), 32'(rf_if.rf_label1), 32'(vecs[i].l1));
        check($sformatf("vec%0d_val1", i),   rf_if.rf_val1,        vecs[i].v1);
        check($sformatf("vec%0d_label2", i), 32'(rf_if.rf_label2), 32'(vecs[i].l2));
        check($sformatf("vec%0d_val2", i),   rf_if.rf_val2,        vecs[i].v2);
      end
    end

    // Random traffic on a small register window so renames, commits and reads collide often.
    for (int n = 0; n < 600; n++) begin
      v.rst   = (n == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
      v.rdy   = ($urandom_range(0, 9) != 0);
      v.flush = ($urandom_range(0, 19) == 0);
      v.den   = $urandom_range(0, 1) == 1;
      v.drd   = 5'($urandom_range(0, 7));
      v.dtag  = 5'($urandom_range(1, 31));
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.cen   = $urandom_range(0, 1) == 1;
      v.crd   = 5'($urandom_range(0, 7));
      v.cres  = $urandom;
      v.clab  = ($urandom_range(0, 1) == 1) ? mlab[v.crd] : 5'($urandom_range(0, 31));
      v.chk   = 1'b1;
      @(negedge clk);
      drive(v);
      #1;
      if (n > 0) begin
        model_read(v, v.rs1, el1, ev1);
        model_read(v, v.rs2, el2, ev2);
        check("rand_label1", 32'(rf_if.rf_label1), 32'(el1));
        check("rand_val1",   rf_if.rf_val1,        ev1);
        check("rand_label2", 32'(rf_if.rf_label2), 32'(el2));
        check("rand_val2",   rf_if.rf_val2,        ev2);
      end
      model_step(v);
    end

    @(negedge clk);
    v = '{default: '0};
    v.rst = 1'b1;
    drive(v);
    #1;
`ifdef RF_PERF_CNT_EN
    check("perf_commit_cnt", rf_if.perf_commit_cnt, mcommits);
    check("perf_rename_cnt", rf_if.perf_rename_cnt, mrenames);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
